// File: rtl/lcd_write_ctrl_if.sv
// Command handshake from the code mapper plus the LCD pin group, bundled for the write controller.
// master = upstream/stimulus side, slave = lcd_write_ctrl.
interface lcd_write_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [5:0] cmd_hi;
    logic [5:0] cmd_lo;
    logic [5:0] lcd_bus;
    logic       lcd_e;
    logic       init_done;

    modport master (
        output cmd_valid, cmd_hi, cmd_lo,
        input  cmd_ready, lcd_bus, lcd_e, init_done
    );

    modport slave (
        input  cmd_valid, cmd_hi, cmd_lo,
        output cmd_ready, lcd_bus, lcd_e, init_done
    );
endinterface

// File: rtl/lcd_write_ctrl.sv
// HD44780 4-bit write sequencer: power-on init, then one byte per valid/ready handshake,
// sent as two E-strobed nibbles followed by the instruction's execution wait.
module lcd_write_ctrl #(
    parameter int unsigned T_PWRUP = 1500000,
    parameter int unsigned T_INIT1 = 410000,
    parameter int unsigned T_INIT2 = 10000,
    parameter int unsigned T_EN    = 25,
    parameter int unsigned T_NIB   = 100,
    parameter int unsigned T_CMD   = 4000,
    parameter int unsigned T_CLR   = 164000
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_write_ctrl_if.slave    bus
);

    localparam int unsigned M0      = (T_PWRUP > T_INIT1) ? T_PWRUP : T_INIT1;
    localparam int unsigned M1      = (M0 > T_CLR) ? M0 : T_CLR;
    localparam int unsigned M2      = (M1 > T_INIT2) ? M1 : T_INIT2;
    localparam int unsigned M3      = (M2 > T_CMD) ? M2 : T_CMD;
    localparam int unsigned M4      = (M3 > T_NIB) ? M3 : T_NIB;
    localparam int unsigned CNT_MAX = (M4 > T_EN) ? M4 : T_EN;
    localparam int          CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_SETUP_HI,
        ST_E_HI,
        ST_HOLD_HI,
        ST_GAP,
        ST_SETUP_LO,
        ST_E_LO,
        ST_HOLD_LO,
        ST_EXEC,
        ST_IDLE
    } state_e;

    typedef struct packed {
        logic          whole;    // full byte; otherwise only the low nibble is sent
        logic [7:0]    data;
        logic [CW-1:0] wait_len;
    } init_cmd_t;

    function automatic logic [CW-1:0] exec_len(input logic rs, input logic [7:0] data);
        exec_len = (!rs && (data == 8'h01 || data == 8'h02)) ? CW'(T_CLR) : CW'(T_CMD);
    endfunction

    // Steps 0..3 are the bare 0x3/0x3/0x3/0x2 nibbles that force 4-bit mode.
    function automatic init_cmd_t init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    init_cmd = '{whole: 1'b0, data: 8'h03, wait_len: CW'(T_INIT1)};
            3'd1:    init_cmd = '{whole: 1'b0, data: 8'h03, wait_len: CW'(T_INIT2)};
            3'd2:    init_cmd = '{whole: 1'b0, data: 8'h03, wait_len: CW'(T_CMD)};
            3'd3:    init_cmd = '{whole: 1'b0, data: 8'h02, wait_len: CW'(T_CMD)};
            3'd4:    init_cmd = '{whole: 1'b1, data: 8'h28, wait_len: exec_len(1'b0, 8'h28)};
            3'd5:    init_cmd = '{whole: 1'b1, data: 8'h0C, wait_len: exec_len(1'b0, 8'h0C)};
            3'd6:    init_cmd = '{whole: 1'b1, data: 8'h01, wait_len: exec_len(1'b0, 8'h01)};
            default: init_cmd = '{whole: 1'b1, data: 8'h06, wait_len: exec_len(1'b0, 8'h06)};
        endcase
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] exec_q, exec_d;
    logic [2:0]    step_q, step_d;
    logic          rs_q, rs_d;
    logic [7:0]    byte_q, byte_d;
    logic [5:0]    lcd_bus_q, lcd_bus_d;
    logic          lcd_e_q, lcd_e_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          init_done_q, init_done_d;

    logic          start_step;
    logic [2:0]    next_step;
    logic          cnt_last;
    init_cmd_t     ic;

    assign cnt_last = (cnt_q == CW'(1));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        exec_d      = exec_q;
        step_d      = step_q;
        rs_d        = rs_q;
        byte_d      = byte_q;
        init_done_d = init_done_q;
        start_step  = 1'b0;
        next_step   = step_q;
        ic          = '0;

        case (state_q)
            ST_PWRUP: begin
                // Counter is cleared by reset, so the first cycle here arms the power-up wait.
                if (cnt_q == '0) begin
                    cnt_d = CW'(T_PWRUP);
                end else if (cnt_last) begin
                    cnt_d      = '0;
                    start_step = 1'b1;
                    next_step  = 3'd0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    rs_d    = bus.cmd_hi[5];
                    byte_d  = {bus.cmd_hi[3:0], bus.cmd_lo[3:0]};
                    exec_d  = exec_len(bus.cmd_hi[5], {bus.cmd_hi[3:0], bus.cmd_lo[3:0]});
                    state_d = ST_SETUP_HI;
                end
            end
            ST_SETUP_HI: begin
                state_d = ST_E_HI;
                cnt_d   = CW'(T_EN);
            end
            ST_E_HI: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_last) state_d = ST_HOLD_HI;
            end
            ST_HOLD_HI: begin
                state_d = ST_GAP;
                cnt_d   = CW'(T_NIB);
            end
            ST_GAP: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_last) state_d = ST_SETUP_LO;
            end
            ST_SETUP_LO: begin
                state_d = ST_E_LO;
                cnt_d   = CW'(T_EN);
            end
            ST_E_LO: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_last) state_d = ST_HOLD_LO;
            end
            ST_HOLD_LO: begin
                state_d = ST_EXEC;
                cnt_d   = exec_q;
            end
            ST_EXEC: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_last) begin
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (step_q == 3'd7) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        start_step = 1'b1;
                        next_step  = step_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_PWRUP;
        endcase

        if (start_step) begin
            ic      = init_cmd(next_step);
            step_d  = next_step;
            rs_d    = 1'b0;
            byte_d  = ic.data;
            exec_d  = ic.wait_len;
            state_d = ic.whole ? ST_SETUP_HI : ST_SETUP_LO;
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with the state register.
    always_comb begin
        lcd_bus_d = lcd_bus_q;
        if (state_d == ST_SETUP_HI) lcd_bus_d = {rs_d, 1'b0, byte_d[7:4]};
        if (state_d == ST_SETUP_LO) lcd_bus_d = {rs_d, 1'b0, byte_d[3:0]};
        lcd_e_d     = (state_d == ST_E_HI) || (state_d == ST_E_LO);
        cmd_ready_d = (state_d == ST_IDLE) && init_done_d;
    end

    // NOTE: sequential state uses non-blocking assignments only; all next-state math lives in always_comb.
    // NOTE: every flop, including the data/byte registers, has the async reset so a mid-byte reset leaves nothing stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= '0;
            exec_q      <= '0;
            step_q      <= 3'd0;
            rs_q        <= 1'b0;
            byte_q      <= 8'h00;
            lcd_bus_q   <= 6'b000000;
            lcd_e_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exec_q      <= exec_d;
            step_q      <= step_d;
            rs_q        <= rs_d;
            byte_q      <= byte_d;
            lcd_bus_q   <= lcd_bus_d;
            lcd_e_q     <= lcd_e_d;
            cmd_ready_q <= cmd_ready_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.lcd_bus   = lcd_bus_q;
    assign bus.lcd_e     = lcd_e_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.init_done = init_done_q;

    // RW and the upper bits of the low word are ignored; the panel is write-only from here.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{bus.cmd_hi[4], bus.cmd_lo[5:4]};

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Self-checking bench for lcd_write_ctrl: a pulse monitor records every E strobe and each
// scenario compares it against nibble lists and busy times derived from the LCD write rules.
module tb_lcd_write_ctrl;

    localparam int T_PWRUP = 20;
    localparam int T_INIT1 = 10;
    localparam int T_INIT2 = 5;
    localparam int T_EN    = 2;
    localparam int T_NIB   = 3;
    localparam int T_CMD   = 4;
    localparam int T_CLR   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_write_ctrl_if bus_if ();

    lcd_write_ctrl #(
        .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_EN(T_EN),
        .T_NIB(T_NIB), .T_CMD(T_CMD), .T_CLR(T_CLR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] bus;
        int         width;
        bit         stable;
    } pulse_t;

    pulse_t     got_q[$];
    logic [5:0] exp_q[$];
    bit         in_pulse = 1'b0;
    pulse_t     cur;

    // E-strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_pulse = 1'b0;
        end else if (bus_if.lcd_e) begin
            if (!in_pulse) begin
                in_pulse   = 1'b1;
                cur.bus    = bus_if.lcd_bus;
                cur.width  = 1;
                cur.stable = 1'b1;
            end else begin
                cur.width++;
                if (bus_if.lcd_bus !== cur.bus) cur.stable = 1'b0;
            end
        end else if (in_pulse) begin
            got_q.push_back(cur);
            in_pulse = 1'b0;
        end
    end

    function automatic int busy_cycles(input logic rs, input logic [7:0] data);
        int exec_t;
        exec_t = (!rs && (data == 8'h01 || data == 8'h02)) ? T_CLR : T_CMD;
        return 2 * (T_EN + 2) + T_NIB + exec_t;
    endfunction

    task automatic expect_byte(input logic rs, input logic [7:0] data);
        exp_q.push_back({rs, 1'b0, data[7:4]});
        exp_q.push_back({rs, 1'b0, data[3:0]});
    endtask

    task automatic check_pulses(input string tag);
        int n;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s pulse_count got %0d expected %0d", tag, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i].bus !== exp_q[i]) begin
                errors++;
                $display("FAIL %s pulse%0d_bus got %b expected %b", tag, i, got_q[i].bus, exp_q[i]);
            end
            checks++;
            if (got_q[i].width != T_EN || !got_q[i].stable) begin
                errors++;
                $display("FAIL %s pulse%0d_shape width %0d stable %0d expected width %0d stable 1",
                         tag, i, got_q[i].width, got_q[i].stable, T_EN);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Call on a falling edge; returns on the falling edge where cmd_ready is seen high.
    task automatic wait_ready(input string tag);
        for (int n = 0; n < 1000; n++) begin
            if (bus_if.cmd_ready) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s ready_timeout got 0 expected 1", tag);
    endtask

    // Counts falling edges with cmd_ready low after an accepting rising edge.
    task automatic count_busy(output int low);
        low = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (bus_if.cmd_ready) return;
            low++;
        end
    endtask

    task automatic send_byte(input logic [5:0] hi, input logic [5:0] lo, input string tag);
        int low;
        logic [7:0] data;
        data = {hi[3:0], lo[3:0]};
        expect_byte(hi[5], data);
        wait_ready(tag);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_hi    = hi;
        bus_if.cmd_lo    = lo;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        low = 1;
        if (!bus_if.cmd_ready) begin
            int more;
            count_busy(more);
            low += more;
        end else begin
            low = 0;
        end
        checks++;
        if (low != busy_cycles(hi[5], data)) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d expected %0d", tag, low, busy_cycles(hi[5], data));
        end
        check_pulses(tag);
    endtask

    task automatic run_init(input bit poke_valid, input string tag);
        logic [3:0] init_nibs[4];
        logic [7:0] init_bytes[4];
        bit early_ready;
        bit done;
        init_nibs  = '{4'h3, 4'h3, 4'h3, 4'h2};
        init_bytes = '{8'h28, 8'h0C, 8'h01, 8'h06};
        bus_if.cmd_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.lcd_bus, bus_if.lcd_e, bus_if.cmd_ready, bus_if.init_done} !== 9'b0) begin
            errors++;
            $display("FAIL %s reset_outputs got bus=%b e=%b rdy=%b done=%b expected all 0", tag,
                     bus_if.lcd_bus, bus_if.lcd_e, bus_if.cmd_ready, bus_if.init_done);
        end
        repeat (3) @(negedge clk);
        got_q.delete();
        exp_q.delete();
        foreach (init_nibs[i]) exp_q.push_back({2'b00, init_nibs[i]});
        foreach (init_bytes[i]) expect_byte(1'b0, init_bytes[i]);
        rst_n = 1'b1;
        early_ready = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (bus_if.init_done) begin
                done = 1'b1;
                break;
            end
            if (bus_if.cmd_ready) early_ready = 1'b1;
            if (poke_valid) begin
                bus_if.cmd_valid = 1'($urandom_range(0, 1));
                bus_if.cmd_hi    = 6'($urandom);
                bus_if.cmd_lo    = 6'($urandom);
            end
        end
        bus_if.cmd_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s init_done_timeout got 0 expected 1", tag);
        end
        checks++;
        if (bus_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_with_done got %b expected 1", tag, bus_if.cmd_ready);
        end
        checks++;
        if (early_ready) begin
            errors++;
            $display("FAIL %s ready_before_init got 1 expected 0", tag);
        end
        check_pulses(tag);
    endtask

    task automatic test_reset();
        run_init(1'b0, "init");
    endtask

    task automatic test_char_a();
        send_byte(6'b100100, 6'b100001, "char_A");
    endtask

    task automatic test_clear_display();
        send_byte(6'b000000, 6'b000001, "clear");
        send_byte(6'b000000, 6'b001100, "display_on");
        send_byte(6'b000000, 6'b000010, "home");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic       rs;
            logic [7:0] data;
            rs   = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rs   = 1'b0;
                data = 8'($urandom_range(1, 2));
            end
            send_byte({rs, 1'($urandom), data[7:4]}, {2'($urandom), data[3:0]},
                      $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        int low;
        bus_if.cmd_hi    = 6'b100011;
        bus_if.cmd_lo    = 6'b100000;
        bus_if.cmd_valid = 1'b1;
        wait_ready("stream");
        for (int i = 0; i < 10; i++) begin
            expect_byte(1'b1, {4'h3, 4'(i)});
            count_busy(low);
            checks++;
            if (low != busy_cycles(1'b1, {4'h3, 4'(i)})) begin
                errors++;
                $display("FAIL stream byte%0d_busy got %0d expected %0d", i, low,
                         busy_cycles(1'b1, {4'h3, 4'(i)}));
            end
            if (i < 9) bus_if.cmd_lo = {2'b10, 4'(i + 1)};
            else bus_if.cmd_valid = 1'b0;
        end
        check_pulses("stream");
    endtask

    task automatic test_valid_during_init();
        run_init(1'b1, "init_poked");
        send_byte(6'b100100, 6'b100001, "after_poke");
    endtask

    task automatic test_reset_mid_byte();
        bit seen_e;
        wait_ready("mid_reset");
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_hi    = 6'b100100;
        bus_if.cmd_lo    = 6'b100010;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        seen_e = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus_if.lcd_e) begin
                seen_e = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen_e) begin
            errors++;
            $display("FAIL mid_reset e_high_timeout got 0 expected 1");
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.lcd_bus, bus_if.lcd_e, bus_if.init_done, bus_if.cmd_ready} !== 9'b0) begin
            errors++;
            $display("FAIL mid_reset async_clear got bus=%b e=%b done=%b rdy=%b expected all 0",
                     bus_if.lcd_bus, bus_if.lcd_e, bus_if.init_done, bus_if.cmd_ready);
        end
        run_init(1'b0, "reinit");
        send_byte(6'b100100, 6'b100001, "after_reinit");
    endtask

    initial begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_hi    = 6'b000000;
        bus_if.cmd_lo    = 6'b000000;
        test_reset();
        test_char_a();
        test_clear_display();
        test_random();
        test_back_to_back();
        test_valid_during_init();
        test_reset_mid_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
